// File: rtl/operand_collector_pkg.sv
// Shared types for the operand collector and the execute stage.
// Provides register-index bounds, per-lane data types, the operand
// bundle stored in the operand FIFO, and the forwarding-eligibility
// helper used for register indices.
package operand_collector_pkg;

    localparam int unsigned REG_ADDR_WIDTH    = 5;
    localparam int unsigned BUNDLE_DATA_WIDTH = 32;
    localparam int unsigned BUNDLE_THREADS    = 4;

    typedef logic [REG_ADDR_WIDTH-1:0]    reg_addr_t;
    typedef logic [BUNDLE_DATA_WIDTH-1:0] data_t;
    typedef data_t [BUNDLE_THREADS-1:0]   lane_data_t;
    typedef logic [BUNDLE_THREADS-1:0]    lane_mask_t;

    // Index 0 is hardwired zero; indices from 29 up are special read-only registers.
    localparam reg_addr_t ZERO_REG          = '0;
    localparam reg_addr_t FIRST_SPECIAL_REG = 5'd29;

    typedef struct packed {
        lane_data_t rs1;
        lane_data_t rs2;
        reg_addr_t  rd;
        data_t      immediate;
        lane_mask_t mask;
    } operand_bundle_t;

    // Only ordinary writable registers can be written back, so only they forward.
    function automatic logic forwardable(input reg_addr_t address);
        return (address != ZERO_REG) && (address < FIRST_SPECIAL_REG);
    endfunction

endpackage

// File: rtl/operand_collector_if.sv
// Issue and operand handshake channels of the operand collector.
//   master : upstream issue logic / execute stage (drives issue_*, op_ready)
//   slave  : the collector (drives issue_ready and op_*)
interface operand_collector_if #(
    parameter int unsigned THREADS_PER_WARP = operand_collector_pkg::BUNDLE_THREADS,
    parameter int unsigned DATA_WIDTH       = operand_collector_pkg::BUNDLE_DATA_WIDTH
);
    logic                                        issue_valid;
    logic                                        issue_ready;
    logic [operand_collector_pkg::REG_ADDR_WIDTH-1:0] issue_rs1_address;
    logic [operand_collector_pkg::REG_ADDR_WIDTH-1:0] issue_rs2_address;
    logic [operand_collector_pkg::REG_ADDR_WIDTH-1:0] issue_rd_address;
    logic [DATA_WIDTH-1:0]                       issue_immediate;
    logic [THREADS_PER_WARP-1:0]                 issue_thread_mask;

    logic                                        op_valid;
    logic                                        op_ready;
    logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] op_rs1;
    logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] op_rs2;
    logic [operand_collector_pkg::REG_ADDR_WIDTH-1:0] op_rd_address;
    logic [DATA_WIDTH-1:0]                       op_immediate;
    logic [THREADS_PER_WARP-1:0]                 op_thread_mask;

    modport master (
        output issue_valid, issue_rs1_address, issue_rs2_address, issue_rd_address,
               issue_immediate, issue_thread_mask, op_ready,
        input  issue_ready, op_valid, op_rs1, op_rs2, op_rd_address, op_immediate,
               op_thread_mask
    );

    modport slave (
        input  issue_valid, issue_rs1_address, issue_rs2_address, issue_rd_address,
               issue_immediate, issue_thread_mask, op_ready,
        output issue_ready, op_valid, op_rs1, op_rs2, op_rd_address, op_immediate,
               op_thread_mask
    );
endinterface

// File: rtl/operand_collector_fifo.sv
// operand_fifo: synchronous FIFO of operand bundles.
//   clk, reset (async, active-low), clear (sync discard)
//   push/push_data, pop, head (entry at read pointer), count, full, empty
// Pointers wrap naturally because DEPTH is a power of two.
module operand_fifo
    import operand_collector_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           push,
    input  operand_bundle_t                push_data,
    input  logic                           pop,
    output operand_bundle_t                head,
    output logic [$clog2(DEPTH + 1)-1:0]   count,
    output logic                           full,
    output logic                           empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    operand_bundle_t  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/operand_collector.sv
// operand_collector: issues register-file reads for decoded instructions,
// captures the synchronous read data one cycle later (S1), applies
// same-cycle writeback forwarding, and queues complete operand bundles
// for the execute stage.
//   clk, reset (async, active-low), flush (sync discard)
//   bus         : issue channel in, operand channel out (slave modport)
//   rf_*        : register-file read strobe, addresses and read data
//   wb_*        : register-file write port observed for forwarding
//   busy        : S1 occupied or FIFO non-empty
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int unsigned THREADS_PER_WARP = BUNDLE_THREADS,
    parameter int unsigned DATA_WIDTH       = BUNDLE_DATA_WIDTH,
    parameter int unsigned DEPTH            = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        flush,
    operand_collector_if.slave                          bus,
    output logic                                        rf_enable,
    output logic [REG_ADDR_WIDTH-1:0]                   rf_rs1_address,
    output logic [REG_ADDR_WIDTH-1:0]                   rf_rs2_address,
    input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] rf_rs1,
    input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] rf_rs2,
    input  logic                                        wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]                   wb_rd_address,
    input  logic [THREADS_PER_WARP-1:0]                 wb_thread_mask,
    input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] wb_data,
    output logic                                        busy
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic             accept, pop, room;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    operand_bundle_t  push_bundle, head;

    logic             s1_valid;
    reg_addr_t        s1_rd;
    data_t            s1_immediate;
    lane_mask_t       s1_mask;
    lane_mask_t       fwd_rs1_mask, fwd_rs2_mask;
    lane_data_t       fwd_rs1_data, fwd_rs2_data;
    lane_mask_t       fwd_rs1_hit, fwd_rs2_hit;

    // Popping this cycle frees a slot, which sustains one bundle per cycle.
    assign pop             = bus.op_valid && bus.op_ready;
    assign occupancy       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
    assign room            = !fifo_full && (occupancy < DEPTH_OCC);
    assign bus.issue_ready = !flush && (room || pop);
    assign accept          = bus.issue_valid && bus.issue_ready;

    assign rf_enable       = accept;
    assign rf_rs1_address  = bus.issue_rs1_address;
    assign rf_rs2_address  = bus.issue_rs2_address;

    // The register file returns pre-write data on a same-cycle write, so
    // written lanes are captured here and substituted at push time.
    assign fwd_rs1_hit = (wb_valid && forwardable(bus.issue_rs1_address) &&
                          (wb_rd_address == bus.issue_rs1_address)) ? wb_thread_mask : '0;
    assign fwd_rs2_hit = (wb_valid && forwardable(bus.issue_rs2_address) &&
                          (wb_rd_address == bus.issue_rs2_address)) ? wb_thread_mask : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid     <= 1'b0;
            s1_rd        <= '0;
            s1_immediate <= '0;
            s1_mask      <= '0;
            fwd_rs1_mask <= '0;
            fwd_rs2_mask <= '0;
            fwd_rs1_data <= '0;
            fwd_rs2_data <= '0;
        end else if (flush) begin
            s1_valid     <= 1'b0;
            fwd_rs1_mask <= '0;
            fwd_rs2_mask <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_rd        <= bus.issue_rd_address;
                s1_immediate <= bus.issue_immediate;
                s1_mask      <= bus.issue_thread_mask;
                fwd_rs1_mask <= fwd_rs1_hit;
                fwd_rs2_mask <= fwd_rs2_hit;
                fwd_rs1_data <= wb_data;
                fwd_rs2_data <= wb_data;
            end
        end
    end

    always_comb begin
        push_bundle           = '0;
        push_bundle.rd        = s1_rd;
        push_bundle.immediate = s1_immediate;
        push_bundle.mask      = s1_mask;
        for (int unsigned i = 0; i < THREADS_PER_WARP; i++) begin
            push_bundle.rs1[i] = fwd_rs1_mask[i] ? fwd_rs1_data[i] : rf_rs1[i];
            push_bundle.rs2[i] = fwd_rs2_mask[i] ? fwd_rs2_data[i] : rf_rs2[i];
        end
    end

    operand_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (s1_valid && !flush),
        .push_data (push_bundle),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FIFO storage is not reset; gating keeps op_* at zero whenever nothing is queued.
    assign bus.op_valid       = !fifo_empty;
    assign bus.op_rs1         = fifo_empty ? '0 : head.rs1;
    assign bus.op_rs2         = fifo_empty ? '0 : head.rs2;
    assign bus.op_rd_address  = fifo_empty ? '0 : head.rd;
    assign bus.op_immediate   = fifo_empty ? '0 : head.immediate;
    assign bus.op_thread_mask = fifo_empty ? '0 : head.mask;

    assign busy = s1_valid || !fifo_empty;

endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;
    import operand_collector_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       rf_enable;
    reg_addr_t  rf_rs1_address, rf_rs2_address;
    lane_data_t rf_rs1_q, rf_rs2_q;
    logic       wb_valid;
    reg_addr_t  wb_rd_address;
    lane_mask_t wb_thread_mask;
    lane_data_t wb_data;
    logic       busy;

    operand_collector_if #(.THREADS_PER_WARP(4), .DATA_WIDTH(32)) bus ();

    operand_collector #(
        .THREADS_PER_WARP(4),
        .DATA_WIDTH(32),
        .DEPTH(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .bus            (bus),
        .rf_enable      (rf_enable),
        .rf_rs1_address (rf_rs1_address),
        .rf_rs2_address (rf_rs2_address),
        .rf_rs1         (rf_rs1_q),
        .rf_rs2         (rf_rs2_q),
        .wb_valid       (wb_valid),
        .wb_rd_address  (wb_rd_address),
        .wb_thread_mask (wb_thread_mask),
        .wb_data        (wb_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Initial register contents: reg5 = 0x11..0x14, reg6 = 0x21..0x24,
    // reg0 = 0, otherwise r*0x100 + lane + 1.
    function automatic lane_data_t init_reg(input int unsigned r);
        lane_data_t v;
        for (int l = 0; l < 4; l++) begin
            if (r == 0)      v[l] = '0;
            else if (r == 5) v[l] = 32'(32'h11 + l);
            else if (r == 6) v[l] = 32'(32'h21 + l);
            else             v[l] = 32'(r * 256 + l + 1);
        end
        return v;
    endfunction

    // Register file: synchronous read, read-during-write returns old data.
    lane_data_t regs [32];
    initial begin
        rf_rs1_q = '0;
        rf_rs2_q = '0;
        for (int r = 0; r < 32; r++) regs[r] = init_reg(r);
        forever begin
            @(posedge clk);
            if (rf_enable) begin
                rf_rs1_q <= regs[rf_rs1_address];
                rf_rs2_q <= regs[rf_rs2_address];
            end
            if (wb_valid && wb_rd_address != 5'd0)
                for (int l = 0; l < 4; l++)
                    if (wb_thread_mask[l]) regs[wb_rd_address][l] <= wb_data[l];
        end
    end

    typedef struct {
        lane_data_t rs1;
        lane_data_t rs2;
        reg_addr_t  rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    logic sb_on = 1'b0;
    int   n_pop = 0;
    int   first_pop = -1;
    int   last_pop = -1;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sb_on && reset) begin
            if (bus.issue_valid && bus.issue_ready) exp_q.push_back(cur_exp);
            if (bus.op_valid && bus.op_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_bundle", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_rs1", bus.op_rs1, e.rs1);
                    check("sb_rs2", bus.op_rs2, e.rs2);
                    check("sb_rd", bus.op_rd_address, e.rd);
                end
                n_pop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input reg_addr_t rs1a, input reg_addr_t rs2a, input reg_addr_t rd,
                         input data_t imm, input lane_mask_t mask);
        bus.issue_valid       = 1'b1;
        bus.issue_rs1_address = rs1a;
        bus.issue_rs2_address = rs2a;
        bus.issue_rd_address  = rd;
        bus.issue_immediate   = imm;
        bus.issue_thread_mask = mask;
        cur_exp.rs1 = init_reg(rs1a);
        cur_exp.rs2 = init_reg(rs2a);
        cur_exp.rd  = rd;
    endtask

    task automatic idle_issue();
        bus.issue_valid = 1'b0;
        wb_valid        = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            step();
            c++;
        end
        check("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    // Issue one instruction (optionally with a same-cycle writeback) and
    // check the bundle that appears two cycles later.
    task automatic run_single(input string tag, input reg_addr_t rs1a, input reg_addr_t rs2a,
                              input reg_addr_t rd, input logic wbv, input reg_addr_t wbrd,
                              input lane_mask_t wbm, input data_t wbd,
                              input lane_data_t exp1, input lane_data_t exp2);
        bus.op_ready = 1'b1;
        offer(rs1a, rs2a, rd, 32'h0, 4'hF);
        wb_valid       = wbv;
        wb_rd_address  = wbrd;
        wb_thread_mask = wbm;
        wb_data        = {4{wbd}};
        step();
        idle_issue();
        step();
        check({tag, "_valid"}, 128'(bus.op_valid), 128'd1);
        check({tag, "_rs1"}, bus.op_rs1, exp1);
        check({tag, "_rs2"}, bus.op_rs2, exp2);
        check({tag, "_rd"}, 128'(bus.op_rd_address), 128'(rd));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_acc;
        reset = 1'b0;
        flush = 1'b0;
        bus.op_ready = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rs1_address = '0;
        bus.issue_rs2_address = '0;
        bus.issue_rd_address = '0;
        bus.issue_immediate = '0;
        bus.issue_thread_mask = '0;
        wb_valid = 1'b0;
        wb_rd_address = '0;
        wb_thread_mask = '0;
        wb_data = '0;

        // Reset state
        repeat (2) step();
        check("rst_op_valid", 128'(bus.op_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_op_rs1", bus.op_rs1, 128'd0);
        check("rst_op_rd", 128'(bus.op_rd_address), 128'd0);
        reset = 1'b1;
        step();
        check("rst_issue_ready", 128'(bus.issue_ready), 128'd1);

        // Single issue: rs1=5, rs2=6
        bus.op_ready = 1'b1;
        offer(5'd5, 5'd6, 5'd7, 32'h1234, 4'hF);
        #1;
        check("t1_rf_enable", 128'(rf_enable), 128'd1);
        check("t1_rf_addr", 128'({rf_rs1_address, rf_rs2_address}), 128'h0A6);
        step();
        idle_issue();
        #1;
        check("t1_rf_enable_drop", 128'(rf_enable), 128'd0);
        check("t1_early_valid", 128'(bus.op_valid), 128'd0);
        check("t1_busy_s1", 128'(busy), 128'd1);
        step();
        check("t1_valid", 128'(bus.op_valid), 128'd1);
        check("t1_rs1", bus.op_rs1, 128'h00000014_00000013_00000012_00000011);
        check("t1_rs2", bus.op_rs2, 128'h00000024_00000023_00000022_00000021);
        check("t1_rd", 128'(bus.op_rd_address), 128'd7);
        check("t1_imm", 128'(bus.op_immediate), 128'h1234);
        check("t1_mask", 128'(bus.op_thread_mask), 128'hF);
        step();
        check("t1_drained", 128'(bus.op_valid), 128'd0);
        check("t1_idle", 128'(busy), 128'd0);

        // Eight back-to-back issues
        sb_on = 1'b1;
        n_pop = 0;
        first_pop = -1;
        for (int k = 0; k < 8; k++) begin
            offer(5'(8 + k), 5'(16 + k), 5'(k), 32'(32'h111 * k), 4'(k) | 4'h1);
            #1;
            check("t2_ready", 128'(bus.issue_ready), 128'd1);
            step();
        end
        idle_issue();
        wait_drain(10);
        check("t2_count", 128'(n_pop), 128'd8);
        check("t2_one_per_cycle", 128'(last_pop - first_pop), 128'd7);

        // Stall: op_ready low with continuous issue_valid
        bus.op_ready = 1'b0;
        n_pop = 0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            offer(5'(12 + n_acc), 5'(24 + n_acc), 5'(20 + n_acc), 32'h0, 4'hF);
            #1;
            if (bus.issue_ready) n_acc++;
            step();
        end
        check("t3_accepts", 128'(n_acc), 128'd2);
        check("t3_ready_low", 128'(bus.issue_ready), 128'd0);
        for (int c = 0; c < 3; c++) begin
            check("t3_head_valid", 128'(bus.op_valid), 128'd1);
            check("t3_head_rs1", bus.op_rs1, init_reg(12));
            check("t3_head_rd", 128'(bus.op_rd_address), 128'd20);
            step();
        end
        idle_issue();
        bus.op_ready = 1'b1;
        wait_drain(10);
        check("t3_count", 128'(n_pop), 128'd2);
        sb_on = 1'b0;
        step();

        // Writeback forwarding
        run_single("t4_fwd_both", 5'd5, 5'd5, 5'd1, 1'b1, 5'd5, 4'b0101, 32'hAA,
                   128'h00000014_000000AA_00000012_000000AA,
                   128'h00000014_000000AA_00000012_000000AA);
        run_single("t4_zero_reg", 5'd0, 5'd6, 5'd2, 1'b1, 5'd0, 4'hF, 32'hBB,
                   128'd0, 128'h00000024_00000023_00000022_00000021);
        run_single("t4_special_reg", 5'd29, 5'd7, 5'd3, 1'b1, 5'd29, 4'hF, 32'hCC,
                   128'h00001D04_00001D03_00001D02_00001D01,
                   128'h00000704_00000703_00000702_00000701);
        run_single("t4_rs2_only", 5'd6, 5'd7, 5'd4, 1'b1, 5'd7, 4'b1000, 32'hDD,
                   128'h00000024_00000023_00000022_00000021,
                   128'h000000DD_00000703_00000702_00000701);

        // Flush with one bundle in S1 and one in the FIFO
        bus.op_ready = 1'b0;
        offer(5'd10, 5'd11, 5'd8, 32'h0, 4'hF);
        step();
        offer(5'd11, 5'd10, 5'd9, 32'h0, 4'hF);
        step();
        offer(5'd12, 5'd13, 5'd10, 32'h0, 4'hF);
        flush = 1'b1;
        #1;
        check("t5_ready_flush", 128'(bus.issue_ready), 128'd0);
        check("t5_rf_enable_flush", 128'(rf_enable), 128'd0);
        check("t5_busy_before", 128'(busy), 128'd1);
        step();
        flush = 1'b0;
        idle_issue();
        check("t5_valid_after", 128'(bus.op_valid), 128'd0);
        check("t5_busy_after", 128'(busy), 128'd0);
        step();
        check("t5_no_stale", 128'(bus.op_valid), 128'd0);
        run_single("t5_post", 5'd10, 5'd11, 5'd11, 1'b0, 5'd0, 4'h0, 32'h0,
                   128'h00000A04_00000A03_00000A02_00000A01,
                   128'h00000B04_00000B03_00000B02_00000B01);

        // Asynchronous reset mid-stream
        bus.op_ready = 1'b0;
        offer(5'd12, 5'd13, 5'd12, 32'h55, 4'hF);
        step();
        idle_issue();
        step();
        check("t6_valid_before", 128'(bus.op_valid), 128'd1);
        #3;
        reset = 1'b0;
        #1;
        check("t6_valid_async", 128'(bus.op_valid), 128'd0);
        check("t6_busy_async", 128'(busy), 128'd0);
        check("t6_rs1_async", bus.op_rs1, 128'd0);
        check("t6_imm_async", 128'(bus.op_immediate), 128'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("t6_ready_release", 128'(bus.issue_ready), 128'd1);
        run_single("t6_post", 5'd14, 5'd15, 5'd13, 1'b0, 5'd0, 4'h0, 32'h0,
                   128'h00000E04_00000E03_00000E02_00000E01,
                   128'h00000F04_00000F03_00000F02_00000F01);
        check("t6_final_idle", 128'(busy), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
